// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared widths and fixed register indices for the multi-port register file
package regfile_mp_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int X0 = 0;
  localparam int A0 = 10;
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: per-register busy bits for issue interlock
module regfile_mp_scoreboard import regfile_mp_pkg::*; #(
  parameter int NREG = NREG_DEF,
  parameter int AW = $clog2(NREG),
  parameter int NWR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  input  logic [NWR-1:0]  wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] nxt;
  always_comb begin
    nxt = busy;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j]) nxt[wr_addr[j*AW +: AW]] = 1'b0;
    // a new producer supersedes a retiring one; flush overrides everything
    if (flush) nxt = '0;
    else if (iss_valid && iss_rd != AW'(X0)) nxt[iss_rd] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= nxt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised NRD-read / NWR-write register file with bypass and busy scoreboard
module regfile_mp import regfile_mp_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW = $clog2(NREG),
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  output logic              any_busy,
  output logic [XLEN-1:0]   dbg_a0
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  function automatic logic hit(input logic [AW-1:0] a);
    logic h;
    h = 1'b0;
    for (int j = 0; j < NWR; j++)
      if (BYPASS != 0 && wr_en[j] && a != AW'(X0) && wr_addr[j*AW +: AW] == a) h = 1'b1;
    return h;
  endfunction
  function automatic logic [XLEN-1:0] rdval(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = regs[a];
    for (int j = 0; j < NWR; j++)
      if (BYPASS != 0 && wr_en[j] && a != AW'(X0) && wr_addr[j*AW +: AW] == a) v = wr_data[j*XLEN +: XLEN];
    return v;
  endfunction
  // later ports overwrite earlier ones, so the highest-index writer wins
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int r = 0; r < NREG; r++) regs[r] <= '0;
    else for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] != AW'(X0)) regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
  regfile_mp_scoreboard #(.NREG(NREG), .AW(AW), .NWR(NWR)) u_sb (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy)
  );
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [XLEN-1:0] v;
    logic h;
    always_comb begin
      v = rdval(rd_addr[i*AW +: AW]);
      h = hit(rd_addr[i*AW +: AW]);
    end
    assign rd_data[i*XLEN +: XLEN] = rst ? '0 : v;
    assign rd_busy[i] = !rst && !h && busy[rd_addr[i*AW +: AW]];
  end
  if (NREG > A0) begin : g_dbg
    logic [XLEN-1:0] v;
    always_comb v = rdval(AW'(A0));
    assign dbg_a0 = rst ? '0 : v;
  end else begin : g_nodbg
    assign dbg_a0 = '0;
  end
  assign any_busy = !rst && |busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of bypass and non-bypass register files against a model
module tb_regfile_mp;
  localparam int XL = 64, NR = 32, AW = 5, NRD = 4, NWR = 2;
  logic clk = 0, rst = 1;
  logic [NRD*AW-1:0] rd_addr;
  logic [NWR-1:0] wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*XL-1:0] wr_data;
  logic iss_valid, flush;
  logic [AW-1:0] iss_rd;
  logic [NRD*XL-1:0] rdb, rdn;
  logic [NRD-1:0] bsb, bsn;
  logic anyb, anyn;
  logic [XL-1:0] a0b, a0n;
  logic [XL-1:0] mreg [NR];
  bit mbusy [NR];
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XL), .NREG(NR), .AW(AW), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdb), .rd_busy(bsb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .flush(flush), .any_busy(anyb), .dbg_a0(a0b));
  regfile_mp #(.XLEN(XL), .NREG(NR), .AW(AW), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdn), .rd_busy(bsn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .flush(flush), .any_busy(anyn), .dbg_a0(a0n));

  function automatic bit written(int a);
    bit w = 0;
    for (int j = 0; j < NWR; j++)
      if (a != 0 && wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) w = 1;
    return w;
  endfunction
  function automatic logic [XL-1:0] exp_rd(int a, bit byp);
    logic [XL-1:0] v = mreg[a];
    if (byp)
      for (int j = 0; j < NWR; j++)
        if (a != 0 && wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*XL +: XL];
    return v;
  endfunction
  function automatic bit exp_busy(int a, bit byp);
    return (byp && written(a)) ? 1'b0 : mbusy[a];
  endfunction
  function automatic bit exp_any();
    bit b = 0;
    for (int r = 0; r < NR; r++) b |= mbusy[r];
    return b;
  endfunction

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_valid = 0; iss_rd = '0; flush = 0;
  endtask
  task automatic set_rd(int p, int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask
  task automatic set_wr(int p, int a, logic [XL-1:0] d);
    wr_en[p] = 1; wr_addr[p*AW +: AW] = AW'(a); wr_data[p*XL +: XL] = d;
  endtask
  task automatic cycle();
    logic [XL-1:0] nr [NR];
    bit nb [NR];
    nr = mreg; nb = mbusy;
    for (int j = 0; j < NWR; j++) if (wr_en[j]) begin
      if (wr_addr[j*AW +: AW] != 0) nr[wr_addr[j*AW +: AW]] = wr_data[j*XL +: XL];
      nb[wr_addr[j*AW +: AW]] = 0;
    end
    if (flush) for (int r = 0; r < NR; r++) nb[r] = 0;
    else if (iss_valid && iss_rd != 0) nb[iss_rd] = 1;
    @(posedge clk); #1;
    mreg = nr; mbusy = nb;
  endtask
  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin mreg[r] = '0; mbusy[r] = 0; end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NRD; i++) set_rd(i, i * 7 + 3);
    #1;
    for (int i = 0; i < NRD; i++) begin
      n_cmp++;
      if (rdb[i*XL +: XL] !== '0 || rdn[i*XL +: XL] !== '0 || bsb[i] !== 0 || bsn[i] !== 0) begin
        n_fail++; $display("FAIL reset_port%0d: data %h/%h busy %b/%b, want 0", i, rdb[i*XL +: XL], rdn[i*XL +: XL], bsb[i], bsn[i]);
      end
    end
    n_cmp++;
    if (anyb !== 0 || anyn !== 0 || a0b !== '0 || a0n !== '0) begin
      n_fail++; $display("FAIL reset_misc: any %b/%b a0 %h/%h, want 0", anyb, anyn, a0b, a0n);
    end
  endtask

  task automatic test_basic();
    idle(); set_rd(0, 3); set_wr(0, 3, 64'h1234); #1;
    n_cmp++;
    if (rdb[XL-1:0] !== 64'h1234) begin n_fail++; $display("FAIL basic_bypass: got %h want 1234", rdb[XL-1:0]); end
    n_cmp++;
    if (rdn[XL-1:0] !== 64'h0) begin n_fail++; $display("FAIL basic_nobypass_old: got %h want 0", rdn[XL-1:0]); end
    cycle(); idle(); #1;
    n_cmp++;
    if (rdb[XL-1:0] !== 64'h1234 || rdn[XL-1:0] !== 64'h1234) begin
      n_fail++; $display("FAIL basic_next: got %h/%h want 1234", rdb[XL-1:0], rdn[XL-1:0]);
    end
  endtask

  task automatic test_x0();
    idle(); set_rd(0, 0); set_wr(0, 0, 64'hFFFF); iss_valid = 1; iss_rd = 0; #1;
    n_cmp++;
    if (rdb[XL-1:0] !== '0 || rdn[XL-1:0] !== '0 || bsb[0] !== 0) begin
      n_fail++; $display("FAIL x0_same: data %h/%h busy %b, want 0", rdb[XL-1:0], rdn[XL-1:0], bsb[0]);
    end
    cycle(); idle(); #1;
    n_cmp++;
    if (rdb[XL-1:0] !== '0 || rdn[XL-1:0] !== '0 || bsb[0] !== 0 || bsn[0] !== 0 || anyb !== 0) begin
      n_fail++; $display("FAIL x0_after: data %h/%h busy %b/%b any %b, want 0", rdb[XL-1:0], rdn[XL-1:0], bsb[0], bsn[0], anyb);
    end
  endtask

  task automatic test_conflict();
    idle(); set_rd(1, 7); set_wr(0, 7, 64'h11); set_wr(1, 7, 64'h22); #1;
    n_cmp++;
    if (rdb[XL +: XL] !== 64'h22) begin n_fail++; $display("FAIL conflict_bypass: got %h want 22", rdb[XL +: XL]); end
    cycle(); idle(); #1;
    n_cmp++;
    if (rdb[XL +: XL] !== 64'h22 || rdn[XL +: XL] !== 64'h22) begin
      n_fail++; $display("FAIL conflict_after: got %h/%h want 22", rdb[XL +: XL], rdn[XL +: XL]);
    end
  endtask

  task automatic test_scoreboard();
    idle(); set_rd(0, 9); iss_valid = 1; iss_rd = 9; cycle(); idle(); #1;
    n_cmp++;
    if (bsb[0] !== 1 || bsn[0] !== 1 || anyb !== 1) begin
      n_fail++; $display("FAIL sb_issue: busy %b/%b any %b, want 1", bsb[0], bsn[0], anyb);
    end
    set_wr(0, 9, 64'h99); iss_valid = 1; iss_rd = 9; #1;
    n_cmp++;
    if (bsb[0] !== 0 || bsn[0] !== 1) begin
      n_fail++; $display("FAIL sb_bypass_busy: busy %b/%b, want 0/1", bsb[0], bsn[0]);
    end
    cycle(); idle(); #1;
    n_cmp++;
    if (bsb[0] !== 1 || bsn[0] !== 1) begin n_fail++; $display("FAIL sb_set_wins: busy %b/%b, want 1", bsb[0], bsn[0]); end
    set_wr(1, 9, 64'h98); cycle(); idle(); #1;
    n_cmp++;
    if (bsb[0] !== 0 || bsn[0] !== 0) begin n_fail++; $display("FAIL sb_clear: busy %b/%b, want 0", bsb[0], bsn[0]); end
    set_rd(0, 4); iss_valid = 1; iss_rd = 4; flush = 1; cycle(); idle(); #1;
    n_cmp++;
    if (bsb[0] !== 0 || bsn[0] !== 0 || anyb !== 0 || anyn !== 0) begin
      n_fail++; $display("FAIL sb_flush: busy %b/%b any %b/%b, want 0", bsb[0], bsn[0], anyb, anyn);
    end
  endtask

  task automatic test_multi_read();
    logic [XL-1:0] want [NRD];
    want[0] = 5; want[1] = 5; want[2] = 0; want[3] = 9;
    idle(); set_wr(0, 1, 64'd5); set_wr(1, 31, 64'd9); cycle(); idle();
    set_rd(0, 1); set_rd(1, 1); set_rd(2, 0); set_rd(3, 31); #1;
    for (int i = 0; i < NRD; i++) begin
      n_cmp++;
      if (rdb[i*XL +: XL] !== want[i] || rdn[i*XL +: XL] !== want[i]) begin
        n_fail++; $display("FAIL multi_read_port%0d: got %h/%h want %h", i, rdb[i*XL +: XL], rdn[i*XL +: XL], want[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      idle();
      for (int i = 0; i < NRD; i++) set_rd(i, (i == 0 && c % 3 == 0) ? 10 : $urandom_range(0, 15));
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 2) != 0) set_wr(j, $urandom_range(0, 15), {$urandom, $urandom});
      iss_valid = $urandom_range(0, 1);
      iss_rd = AW'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      #1;
      for (int i = 0; i < NRD; i++) begin
        int a = int'(rd_addr[i*AW +: AW]);
        n_cmp++;
        if (rdb[i*XL +: XL] !== exp_rd(a, 1) || rdn[i*XL +: XL] !== exp_rd(a, 0)) begin
          n_fail++; $display("FAIL rand_data c%0d p%0d r%0d: got %h/%h want %h/%h", c, i, a, rdb[i*XL +: XL], rdn[i*XL +: XL], exp_rd(a, 1), exp_rd(a, 0));
        end
        n_cmp++;
        if (bsb[i] !== exp_busy(a, 1) || bsn[i] !== exp_busy(a, 0)) begin
          n_fail++; $display("FAIL rand_busy c%0d p%0d r%0d: got %b/%b want %b/%b", c, i, a, bsb[i], bsn[i], exp_busy(a, 1), exp_busy(a, 0));
        end
      end
      n_cmp++;
      if (anyb !== exp_any() || anyn !== exp_any() || a0b !== exp_rd(10, 1) || a0n !== exp_rd(10, 0)) begin
        n_fail++; $display("FAIL rand_misc c%0d: any %b/%b a0 %h/%h want %b %h/%h", c, anyb, anyn, a0b, a0n, exp_any(), exp_rd(10, 1), exp_rd(10, 0));
      end
      cycle();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); set_wr(0, 5, 64'hDEAD); iss_valid = 1; iss_rd = 6; cycle(); idle();
    set_rd(0, 5); set_rd(1, 6); set_wr(1, 5, 64'hBEEF); #2;
    rst = 1; #1;
    n_cmp++;
    if (rdb[XL-1:0] !== '0 || rdn[XL-1:0] !== '0) begin
      n_fail++; $display("FAIL reset_mid_data: got %h/%h want 0", rdb[XL-1:0], rdn[XL-1:0]);
    end
    n_cmp++;
    if (bsb !== '0 || bsn !== '0 || anyb !== 0 || anyn !== 0) begin
      n_fail++; $display("FAIL reset_mid_busy: busy %b/%b any %b/%b want 0", bsb, bsn, anyb, anyn);
    end
    idle(); model_clear();
    @(negedge clk); rst = 0; @(posedge clk); #1;
    n_cmp++;
    if (rdn[XL-1:0] !== '0 || bsn[1] !== 0) begin
      n_fail++; $display("FAIL reset_mid_after: r5 %h busy6 %b want 0", rdn[XL-1:0], bsn[1]);
    end
  endtask

  initial begin
    rd_addr = '0; idle(); model_clear();
    #12;
    test_reset();
    @(negedge clk); rst = 0; @(posedge clk); #1;
    test_basic();
    test_x0();
    test_conflict();
    test_scoreboard();
    test_multi_read();
    test_random();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core; replaces the fixed 2R1W register file.
- Generalised in read-port count, write-port count, width and depth.
- Adds an optional same-cycle write-to-read bypass, a per-register busy scoreboard for issue interlock, and asynchronous reset of all architectural state.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
XLEN, 64, register data width
NREG, 32, number of registers (power of two, >=2); register 0 hardwired to zero
AW, $clog2(NREG), register address width
NRD, 2, number of read ports (>=1)
NWR, 1, number of write ports (>=1)
BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  busy flag of the register addressed on each read port
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
iss_valid  in  1  issue of an instruction with a destination register
iss_rd  in  AW  destination register of the issuing instruction
flush  in  1  clear all busy bits (pipeline flush)
any_busy  out  1  OR of all busy bits
dbg_a0  out  XLEN  current value of register 10 (debug)

Behaviour:
- Reset:
  - rst high asynchronously clears all registers and all busy bits to 0.
  - While rst is high, rd_data = 0, rd_busy = 0, any_busy = 0, dbg_a0 = 0.
  - A write or issue in the same cycle that rst deasserts is ignored.
- Register 0:
  - Always reads 0 and always reports busy 0.
  - Writes and issues targeting it are discarded.
- Writes:
  - Registered at posedge clk when wr_en[j] is set.
  - If several ports write the same address in one cycle, the highest-index port wins.
- Reads:
  - Combinational, zero latency.
  - BYPASS=1: if any wr_en[j] is set with wr_addr[j] == rd_addr[i] != 0, rd_data[i] = wr_data[j] of the highest such j.
  - BYPASS=0: the stored value is returned; the write becomes visible the next cycle.
- Scoreboard:
  - busy[r] is set at posedge when iss_valid is high and iss_rd == r != 0.
  - busy[r] is cleared at posedge when any wr_en[j] is high with wr_addr[j] == r.
  - Set and clear of the same r in the same cycle: set wins, because the new producer supersedes the old one.
  - flush clears all busy bits and has priority over iss_valid.
  - Writes still proceed during flush.
- rd_busy:
  - rd_busy[i] = busy[rd_addr[i]], qualified by the bypass.
  - With BYPASS=1, a same-cycle write to the register forces rd_busy[i] = 0.
- dbg_a0 follows the same bypass rule as the read ports.
- The block has no handshake stall; the consumer must interlock on rd_busy.

Decomposition:
- The shared defines header supplies XLEN, the register address width and the x0 index constant.
- One natural sub-module, regfile_scoreboard, holds the NREG busy bits with their set/clear/flush logic and exposes busy[NREG].
- Bypass and priority muxing stay in the top level as generate loops over NRD and NWR.

Test Plan:
- Reset mid-operation: write r5 = 0xDEAD, assert rst asynchronously between clock edges -> rd_data for r5 = 0 immediately, busy all 0, any_busy = 0.
- Basic write/read, BYPASS=0: write r3 = 0x1234 at cycle N -> read r3 returns old value 0 in cycle N and 0x1234 in N+1. With BYPASS=1 -> 0x1234 in cycle N.
- x0 immunity: write r0 = 0xFFFF and issue iss_rd = 0 -> r0 reads 0, rd_busy = 0, any_busy = 0.
- Multi-write conflict (NWR=2): port0 writes r7 = 0x11 and port1 writes r7 = 0x22 in the same cycle -> r7 = 0x22 afterwards, and bypass returns 0x22 in that cycle.
- Scoreboard: issue r9 -> next cycle rd_busy = 1. Writeback r9 together with a new issue of r9 in one cycle -> r9 stays busy. Writeback r9 alone -> busy clears. Issue r4 with flush -> r4 not busy.
- Multi-read (NRD=4): ports read r1, r1, r0, r31 with r1 = 5 and r31 = 9 -> outputs 5, 5, 0, 9 in the same cycle.
